// File: rtl/median_pkg.sv
// Shared types and frame-geometry helpers for the sequential median engine.
// The build-time macro MEDIAN_MINMAX_EN is consumed by median_seq_ctrl, not here.
package median_pkg;

    localparam int DEFAULT_DATA_W = 4;
    localparam int DEFAULT_N      = 9;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index of the median once buf is sorted ascending.
    function automatic int mid_of(input int n);
        return (n - 1) / 2;
    endfunction

    // Compare-exchange pairs visited in one transposition phase.
    function automatic int pairs_of(input int n);
        return (n - 1) / 2;
    endfunction

    // Total compare-exchange cycles needed to fully sort a frame.
    function automatic int sort_cycles_of(input int n);
        return n * pairs_of(n);
    endfunction

endpackage

// File: rtl/median_seq_ctrl_comparator2.sv
// Comparator2: a single unsigned 2-input compare-exchange cell (min/max).
// Equal inputs pass straight through; swapping them would give the same result.
module comparator2 #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y_min,
    output logic [W-1:0] y_max
);

    logic swap;

    assign swap  = (b < a);
    assign y_min = swap ? b : a;
    assign y_max = swap ? a : b;

endmodule

// File: rtl/median_seq_ctrl.sv
// Sequential median engine: loads N samples, sorts them by odd-even transposition
// on one shared comparator, then offers buf[MID]. Define MEDIAN_MINMAX_EN for out_min/out_max.
module median_seq_ctrl
    import median_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int N      = DEFAULT_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_median,
    output logic              busy
`ifdef MEDIAN_MINMAX_EN
   ,output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max
`endif
);

    localparam int MID = mid_of(N);
    localparam int P   = pairs_of(N);
    localparam int CW  = $clog2(N + 1);

    localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
    localparam logic [CW-1:0] PAIR_LAST = CW'(P - 1);

    state_t state_q, state_d;

    logic [DATA_W-1:0] buf_q [N];
    logic [CW-1:0]     wr_cnt_q;
    logic [CW-1:0]     phase_q;
    logic [CW-1:0]     pair_q;

    logic [CW-1:0]     lo_idx;
    logic [CW-1:0]     hi_idx;
    logic [DATA_W-1:0] cmp_a, cmp_b;
    logic [DATA_W-1:0] cmp_min, cmp_max;
    logic              accept;
    logic              load_last;
    logic              sort_last;

    assign accept    = in_valid & in_ready;
    assign load_last = (wr_cnt_q == LAST_IDX);
    assign sort_last = (phase_q == LAST_IDX) && (pair_q == PAIR_LAST);

    // Even phases pair (0,1),(2,3)...; odd phases shift by one to (1,2),(3,4)...
    assign lo_idx = {pair_q[CW-2:0], 1'b0} + CW'(phase_q[0]);
    assign hi_idx = lo_idx + CW'(1);
    assign cmp_a  = buf_q[lo_idx];
    assign cmp_b  = buf_q[hi_idx];

    comparator2 #(
        .W (DATA_W)
    ) u_cmp (
        .a     (cmp_a),
        .b     (cmp_b),
        .y_min (cmp_min),
        .y_max (cmp_max)
    );

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD: if (accept && load_last) state_d = ST_SORT;
            ST_SORT: if (sort_last)           state_d = ST_DONE;
            ST_DONE: if (out_ready)           state_d = ST_LOAD;
            default:                          state_d = ST_LOAD;
        endcase
    end

    // Handshake outputs decode only the state register: no in->out combinational paths.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            ST_LOAD: in_ready  = 1'b1;
            ST_SORT: busy      = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // NOTE: buf is reset because out_median must read 0 straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
            wr_cnt_q <= '0;
            phase_q  <= '0;
            pair_q   <= '0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        buf_q[wr_cnt_q] <= in_data;
                        wr_cnt_q        <= load_last ? '0 : wr_cnt_q + CW'(1);
                    end
                end
                ST_SORT: begin
                    buf_q[lo_idx] <= cmp_min;
                    buf_q[hi_idx] <= cmp_max;
                    if (pair_q == PAIR_LAST) begin
                        pair_q  <= '0;
                        phase_q <= (phase_q == LAST_IDX) ? '0 : phase_q + CW'(1);
                    end else begin
                        pair_q <= pair_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        wr_cnt_q <= '0;
                        phase_q  <= '0;
                        pair_q   <= '0;
                    end
                end
                default: begin
                    wr_cnt_q <= '0;
                end
            endcase
        end
    end

    assign out_median = buf_q[MID];

`ifdef MEDIAN_MINMAX_EN
    assign out_min = buf_q[0];
    assign out_max = buf_q[N-1];
`endif

endmodule

// File: tb/tb_median_seq_ctrl.sv
// Directed bench for median_seq_ctrl: an N=9 and an N=3 instance, hand-computed medians,
// latency, backpressure and reset-abort behaviour. Honours MEDIAN_MINMAX_EN if defined.
module tb_median_seq_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic       in_valid9, in_ready9, out_valid9, out_ready9, busy9;
    logic [3:0] in_data9, out_median9;
    logic       in_valid3, in_ready3, out_valid3, out_ready3, busy3;
    logic [3:0] in_data3, out_median3;
`ifdef MEDIAN_MINMAX_EN
    logic [3:0] out_min9, out_max9, out_min3, out_max3;
`endif

    median_seq_ctrl #(.DATA_W(4), .N(9)) dut9 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid9),
        .in_ready   (in_ready9),
        .in_data    (in_data9),
        .out_valid  (out_valid9),
        .out_ready  (out_ready9),
        .out_median (out_median9),
        .busy       (busy9)
`ifdef MEDIAN_MINMAX_EN
       ,.out_min    (out_min9),
        .out_max    (out_max9)
`endif
    );

    median_seq_ctrl #(.DATA_W(4), .N(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid3),
        .in_ready   (in_ready3),
        .in_data    (in_data3),
        .out_valid  (out_valid3),
        .out_ready  (out_ready3),
        .out_median (out_median3),
        .busy       (busy3)
`ifdef MEDIAN_MINMAX_EN
       ,.out_min    (out_min3),
        .out_max    (out_max3)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int acc9     = 0;

    always @(posedge clk) begin
        if (in_valid9 && in_ready9) acc9++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Offer one sample on the selected instance and hold it until accepted.
    task automatic push(input bit sel3, input logic [3:0] d);
        int guard;
        guard = 0;
        @(negedge clk);
        if (sel3) begin in_valid3 = 1'b1; in_data3 = d; end
        else      begin in_valid9 = 1'b1; in_data9 = d; end
        while (!(sel3 ? in_ready3 : in_ready9) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (sel3) in_valid3 = 1'b0;
        else      in_valid9 = 1'b0;
    endtask

    task automatic push_frame9(input logic [3:0] f [9]);
        for (int i = 0; i < 9; i++) push(1'b0, f[i]);
    endtask

    // Called just after the last accepting edge; returns at the negedge where out_valid is seen.
    task automatic wait_done(input bit sel3, output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = 0;
        forever begin
            @(negedge clk);
            if (sel3 ? busy3 : busy9) busy_cycles++;
            if ((sel3 ? out_valid3 : out_valid9) || cycles >= 200) break;
            @(posedge clk);
            cycles++;
        end
        if (cycles >= 200) check("done_timeout", 32'd0, 32'd1);
    endtask

    logic [3:0] frame [9];
    int cyc, bcyc, acc_start;

    initial begin
        rst = 1'b1;
        in_valid9 = 1'b0; in_data9 = '0; out_ready9 = 1'b1;
        in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready9",   in_ready9,   1);
        check("rst_out_valid9",  out_valid9,  0);
        check("rst_busy9",       busy9,       0);
        check("rst_median9",     out_median9, 0);
        check("rst_in_ready3",   in_ready3,   1);
        check("rst_out_valid3",  out_valid3,  0);

        // Frame 1: sorted 0,1,2,3,4,7,8,9,15 -> 4, latency 36, one-cycle out_valid.
        acc_start = acc9;
        frame = '{4'd9, 4'd3, 4'd7, 4'd1, 4'd15, 4'd0, 4'd8, 4'd2, 4'd4};
        push_frame9(frame);
        check("f1_busy_after_last", busy9, 1);
        check("f1_in_ready_low",    in_ready9, 0);
        wait_done(1'b0, cyc, bcyc);
        check("f1_latency",  cyc, 36);
        check("f1_median",   out_median9, 4);
        check("f1_accepts",  acc9 - acc_start, 9);
        @(negedge clk);
        check("f1_valid_one_cycle", out_valid9, 0);
        check("f1_in_ready_back",   in_ready9,  1);

        // Frame 2: descending 15..7 -> median 11, min 7, max 15.
        frame = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8, 4'd7};
        push_frame9(frame);
        wait_done(1'b0, cyc, bcyc);
        check("f2_median", out_median9, 11);
`ifdef MEDIAN_MINMAX_EN
        check("f2_min", out_min9, 7);
        check("f2_max", out_max9, 15);
`endif

        // Frame 3: all fives with a bubble between every sample.
        acc_start = acc9;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            push(1'b0, 4'd5);
        end
        wait_done(1'b0, cyc, bcyc);
        check("f3_accepts",    acc9 - acc_start, 9);
        check("f3_median",     out_median9, 5);
        check("f3_busy_cycles", bcyc, 36);
        check("f3_latency",    cyc, 36);

        // Frame 4: backpressure. Sorted 0,0,0,1,2,15,15,15,15 -> 2.
        @(negedge clk);
        out_ready9 = 1'b0;
        frame = '{4'd0, 4'd0, 4'd0, 4'd15, 4'd15, 4'd15, 4'd15, 4'd1, 4'd2};
        push_frame9(frame);
        wait_done(1'b0, cyc, bcyc);
        check("bp_median_first", out_median9, 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid_held",  out_valid9,  1);
            check("bp_median_held", out_median9, 2);
            check("bp_in_ready_lo", in_ready9,   0);
        end
        out_ready9 = 1'b1;
        @(negedge clk);
        check("bp_valid_drop", out_valid9, 0);
        check("bp_in_ready",   in_ready9,  1);

        // Reset mid-SORT, then reset mid-LOAD, then a clean frame 1..9 -> 5.
        frame = '{4'd9, 4'd3, 4'd7, 4'd1, 4'd15, 4'd0, 4'd8, 4'd2, 4'd4};
        push_frame9(frame);
        repeat (5) @(negedge clk);
        check("abort_busy_before", busy9, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready",  in_ready9,  1);
        check("abort_out_valid", out_valid9, 0);
        check("abort_busy",      busy9,      0);
        push(1'b0, 4'd15);
        push(1'b0, 4'd15);
        push(1'b0, 4'd15);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        frame = '{4'd3, 4'd8, 4'd1, 4'd9, 4'd5, 4'd2, 4'd7, 4'd4, 4'd6};
        push_frame9(frame);
        wait_done(1'b0, cyc, bcyc);
        check("abort_median", out_median9, 5);
        check("abort_latency", cyc, 36);

        // N=3: 2,9,5 -> 5 after three compare edges; traffic during SORT is ignored.
        push(1'b1, 4'd2);
        push(1'b1, 4'd9);
        push(1'b1, 4'd5);
        in_valid3 = 1'b1;
        in_data3  = 4'd15;
        check("n3_in_ready_busy", in_ready3, 0);
        wait_done(1'b1, cyc, bcyc);
        in_valid3 = 1'b0;
        check("n3_latency", cyc, 3);
        check("n3_median",  out_median3, 5);
        check("n3_busy_cycles", bcyc, 3);
        @(negedge clk);
        check("n3_valid_drop", out_valid3, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/median_seq_ctrl.md
# median_seq_ctrl

Sequential median engine that collects a frame of N samples over a valid/ready input port, sorts them with one time-shared 2-input compare-exchange unit, and returns the median over a valid/ready output port. It sits between a sample source (e.g. a 3x3 window scanner) and the consumer of filtered pixels. It trades latency for area against a fully parallel comparator network.

## Interface
- DATA_W, 4: sample width in bits, unsigned.
- N, 9: frame size. Must be odd, 3..9.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  sample offered.
- in_ready  out  1  engine accepts a sample this cycle.
- in_data  in  DATA_W  sample value.
- out_valid  out  1  median available.
- out_ready  in  1  consumer takes the median.
- out_median  out  DATA_W  median of the current frame.
- busy  out  1  high in SORT state.

## Operation
- Buffer: buf[0..N-1] of DATA_W bits. MID = (N-1)/2. P = (N-1)/2 pairs per phase. S = N*P sort cycles (36 for N=9, 3 for N=3).
- States: LOAD, SORT, DONE.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, buf[wr_cnt] <= in_data and wr_cnt increments.
  - The Nth accept clears wr_cnt and moves to SORT.
  - in_valid low is a bubble: no state change.
- SORT (odd-even transposition):
  - in_ready=0, busy=1. Counters: phase 0..N-1, pair 0..P-1.
  - Each cycle the single comparator sees lo = 2*pair + phase[0], hi = lo+1.
  - buf[lo] <= min and buf[hi] <= max. Equal values need no swap; the result is identical either way.
  - pair wraps to 0 and phase increments. After phase N-1, pair P-1, the state moves to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - On out_ready, the state moves to LOAD with counters at 0.
  - out_valid is never withdrawn without out_ready.
- out_median = buf[MID] (combinational). It is meaningful only while out_valid=1.
- Inputs presented outside LOAD are ignored and do not corrupt buf.

## Timing
- Reset values:
  - state=LOAD, all buf/counters 0.
  - in_ready=1, out_valid=0, busy=0, out_median=0.
- Latency: with the Nth sample accepted at edge E0, compare-exchanges occur at E1..ES. out_valid rises after ES.
- Throughput: one frame per N + S + 1 cycles minimum. The DONE→LOAD handshake cycle accepts no sample, so in_ready rises in the cycle after the output handshake.
- Backpressure: while out_ready=0 in DONE, out_valid, out_median and buf hold.
- Reset mid-frame or mid-SORT aborts the frame. The next cycle shows LOAD, in_ready=1 and out_valid=0, and partial samples are discarded.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Configuration
- MEDIAN_MINMAX_EN defined:
  - Adds ports out_min (buf[0]) and out_max (buf[N-1]), both DATA_W.
  - They have the same validity and hold rules as out_median.
- MEDIAN_MINMAX_EN undefined: the ports do not exist. Median behaviour and latency are identical in both builds.

## Structure
- Package median_pkg:
  - state enum (LOAD, SORT, DONE);
  - default DATA_W and N;
  - functions giving MID, P and S from N.
- One sub-module: the existing Comparator2, instantiated exactly once. Its A/B inputs are muxed from buf[lo]/buf[hi], and its max/min outputs are written back. No second comparator may be inferred.
- The sequencer (FSM, counters, operand mux, write-back) lives in median_seq_ctrl itself.

## Test plan
- N=9, feed 9,3,7,1,15,0,8,2,4 back-to-back, out_ready=1 -> out_median=4. out_valid rises exactly 36 edges after the last accept and lasts 1 cycle.
- N=9, descending 15..7 -> out_median=11. With MEDIAN_MINMAX_EN: out_min=7, out_max=15.
- N=9, all samples 5, with in_valid bubbles every other cycle -> only 9 accepts counted, out_median=5, busy high for 36 cycles.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid=1 and out_median stable, in_ready=0 throughout. Then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 on the next cycle.
- Assert rst during SORT of frame 9,3,7,1,15,0,8,2,4 -> next cycle LOAD, in_ready=1, out_valid=0. Then frame 1..9 -> out_median=5.
- N=3, feed 2,9,5 -> out_median=5 three edges after the last accept. In_data presented while busy has no effect.
